pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Stall, flush and memory-wait controller for the five-stage MIPS pipeline. Each cycle it generates the enable and flush controls for the PC and the four pipeline registers (F/D, D/X, X/M, M/W), including the `enable` input of the X/M register. It resolves three conditions:

- load-use hazards;
- taken branches resolved in execute;
- multi-cycle data-memory accesses.

A watchdog detects a memory access that never completes, and a counter accumulates total stall cycles for performance debug.

## Interface
- MEM_TIMEOUT, 15: consecutive not-ready memory cycles tolerated before lock-up. Must be ≥ 2.
- clock  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- d_rs  in  5  rs field of the instruction in decode
- d_rt  in  5  rt field of the instruction in decode
- d_uses_rt  in  1  the decode instruction reads rt as a source
- x_rt  in  5  destination rt of the instruction in execute
- x_mem_read  in  1  the instruction in execute is a load
- x_branch_taken  in  1  branch in execute resolved taken this cycle
- m_mem_enable  in  1  X/M stage holds an active memory access (X/M `mem_enable_out`)
- mem_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC update enable
- fd_enable  out  1  F/D register enable
- dx_enable  out  1  D/X register enable
- xm_enable  out  1  X/M register enable
- mw_enable  out  1  M/W register enable
- fd_flush  out  1  load a NOP into F/D at the next edge
- dx_flush  out  1  load a NOP into D/X at the next edge
- mem_timeout  out  1  sticky memory lock-up flag
- stall_count  out  16  saturating count of cycles with pc_enable=0

## Operation
- State register: RUN, MEM_WAIT, TIMEOUT. Internal `wait_cnt` is $clog2(MEM_TIMEOUT) bits.
- Outputs are combinational (Mealy) from state and inputs. Evaluate in priority order 1 > 2 > 3 > 4.

**Priority 1 — memory stall** (RUN with m_mem_enable=1 & mem_ready=0, or any MEM_WAIT cycle with m_mem_enable=1 & mem_ready=0):
- all five enables 0; both flushes 0.
- RUN → MEM_WAIT; wait_cnt ← 1.
- In MEM_WAIT: if wait_cnt == MEM_TIMEOUT-1, go to TIMEOUT; else wait_cnt+1.

**Priority 2 — branch flush** (x_branch_taken=1):
- all enables 1; fd_flush=1; dx_flush=1.

**Priority 3 — load-use** (x_mem_read=1 & x_rt≠0 & (x_rt==d_rs | (d_uses_rt & x_rt==d_rt))):
- pc_enable=0, fd_enable=0; dx_enable=1, dx_flush=1 (bubble); xm_enable=1, mw_enable=1.
- Lasts exactly one cycle, because the load advances to memory.

**Priority 4 — normal:**
- all enables 1; flushes 0.

**MEM_WAIT exit:**
- A cycle with mem_ready=1, or m_mem_enable=0, is evaluated as RUN (priorities 2–4 apply the same cycle). Next state RUN; wait_cnt ← 0.

**TIMEOUT:**
- all enables 0, flushes 0, mem_timeout=1.
- Held until reset; mem_ready is ignored.

**stall_count:**
- +1 on each edge where pc_enable=0 and state≠TIMEOUT.
- Saturates at 16'hFFFF.

**Reset:**
- While reset=1: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0; all enables 0, flushes 0, regardless of inputs.
- Reset mid-MEM_WAIT or in TIMEOUT abandons the access immediately.

## Timing
- Zero-cycle control latency: outputs respond combinationally to inputs in the same cycle; pipeline registers act at the following edge.
- Memory access ready on its first cycle: no stall.
- An access ready after N not-ready cycles stalls exactly N cycles, for N < MEM_TIMEOUT.
- The MEM_TIMEOUT-th consecutive not-ready cycle enters TIMEOUT at the next edge; mem_timeout rises then.
- Load-use: 1 stall cycle.
- Taken branch: 2 flushed slots and 0 stall cycles.
- Branch during memory stall: ignored until the stall clears. The branch is still held in X and resolves on the release cycle.
- Deassertion of reset is synchronized externally; the first edge after deassertion evaluates in RUN.

## Test plan
- Load `lw $5` in X, decode `add` with rs=5 → one cycle of pc_enable=0, fd_enable=0, dx_flush=1; the next cycle is normal; stall_count=1.
- x_rt=0 with a matching d_rs=0 and x_mem_read=1 → no stall; all enables 1.
- m_mem_enable=1 with mem_ready low for 3 cycles, then high → all enables 0 for exactly 3 cycles, state returns to RUN, stall_count=3, mem_timeout stays 0.
- MEM_TIMEOUT=15, mem_ready held 0 → enables 0 throughout; mem_timeout=1 from cycle 16; stall_count frozen at 15; reset pulse clears all to 0 and RUN.
- x_branch_taken=1 together with a load-use match, then again together with a memory stall → first case: fd_flush=dx_flush=1 with all enables 1; second case: all enables 0 and no flush until mem_ready, then flushes on the release cycle.
- Force stall_count near 16'hFFFE via a long load-use stimulus → the count reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
//
// Groups the decode/execute/memory hazard inputs and the pipeline control
// outputs of pipeline_hazard_ctrl.
//   slave  : the controller (hazard inputs in, enables/flushes/status out)
//   master : the pipeline side (drives hazard inputs, consumes controls)
interface pipeline_hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_uses_rt;
  logic [4:0]  x_rt;
  logic        x_mem_read;
  logic        x_branch_taken;
  logic        m_mem_enable;
  logic        mem_ready;

  logic        pc_enable;
  logic        fd_enable;
  logic        dx_enable;
  logic        xm_enable;
  logic        mw_enable;
  logic        fd_flush;
  logic        dx_flush;
  logic        mem_timeout;
  logic [15:0] stall_count;

  modport slave (
    input  d_rs, d_rt, d_uses_rt, x_rt, x_mem_read, x_branch_taken,
           m_mem_enable, mem_ready,
    output pc_enable, fd_enable, dx_enable, xm_enable, mw_enable,
           fd_flush, dx_flush, mem_timeout, stall_count
  );

  modport master (
    output d_rs, d_rt, d_uses_rt, x_rt, x_mem_read, x_branch_taken,
           m_mem_enable, mem_ready,
    input  pc_enable, fd_enable, dx_enable, xm_enable, mw_enable,
           fd_flush, dx_flush, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/memory-wait controller for a 5-stage pipeline
//
// Ports:
//   clock : pipeline clock, rising edge
//   reset : asynchronous, active-high
//   hz    : pipeline_hazard_ctrl_if.slave
//           in : d_rs, d_rt, d_uses_rt, x_rt, x_mem_read, x_branch_taken,
//                m_mem_enable, mem_ready
//           out: pc/fd/dx/xm/mw_enable, fd_flush, dx_flush, mem_timeout,
//                stall_count[15:0]
// Controls are Mealy outputs; priority is memory stall > taken branch >
// load-use > normal. A memory access not ready for MEM_TIMEOUT consecutive
// cycles locks the controller in TIMEOUT until reset.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]    stall_count_q, stall_count_d;

  logic pc_enable, fd_enable, dx_enable, xm_enable, mw_enable;
  logic fd_flush, dx_flush, mem_timeout;
  logic mem_stall, load_use;

  assign mem_stall = hz.m_mem_enable & ~hz.mem_ready;

  // A load targeting $0 never creates a dependency.
  assign load_use = hz.x_mem_read && (hz.x_rt != 5'd0) &&
                    ((hz.x_rt == hz.d_rs) || (hz.d_uses_rt && (hz.x_rt == hz.d_rt)));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_enable   = 1'b0;
    fd_enable   = 1'b0;
    dx_enable   = 1'b0;
    xm_enable   = 1'b0;
    mw_enable   = 1'b0;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;
    mem_timeout = 1'b0;

    // Reset holds every control low regardless of the hazard inputs.
    if (!reset) begin
      if (state_q == ST_TIMEOUT) begin
        mem_timeout = 1'b1;
      end else if (mem_stall) begin
        // Whole pipeline frozen; a held branch waits for the release cycle.
        if (state_q == ST_RUN) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end else begin
        // A completing (or absent) access is evaluated exactly as RUN.
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        if (hz.x_branch_taken) begin
          pc_enable = 1'b1;
          fd_enable = 1'b1;
          dx_enable = 1'b1;
          xm_enable = 1'b1;
          mw_enable = 1'b1;
          fd_flush  = 1'b1;
          dx_flush  = 1'b1;
        end else if (load_use) begin
          // Hold PC and F/D, inject a bubble into D/X, let the load advance.
          dx_enable = 1'b1;
          dx_flush  = 1'b1;
          xm_enable = 1'b1;
          mw_enable = 1'b1;
        end else begin
          pc_enable = 1'b1;
          fd_enable = 1'b1;
          dx_enable = 1'b1;
          xm_enable = 1'b1;
          mw_enable = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_enable && (state_q != ST_TIMEOUT) && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.pc_enable   = pc_enable;
  assign hz.fd_enable   = fd_enable;
  assign hz.dx_enable   = dx_enable;
  assign hz.xm_enable   = xm_enable;
  assign hz.mw_enable   = mw_enable;
  assign hz.fd_flush    = fd_flush;
  assign hz.dx_flush    = dx_flush;
  assign hz.mem_timeout = mem_timeout;
  assign hz.stall_count = stall_count_q;

endmodule
